// File: rtl/instr_issue.sv
// Instruction issue stage: a DEPTH-entry FIFO feeding a register-bank pipe.
// Define ISSUE_HAZARD_CHK_EN to enable per-register busy tracking and RAW stalls.
module instr_issue #(
  parameter int DEPTH   = 4,
  parameter int HAZ_LAT = 3
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_instr,
  input  logic                     issue_en,
  output logic [3:0]               rs1,
  output logic [3:0]               rs2,
  output logic [3:0]               rd,
  output logic [3:0]               func,
  output logic [7:0]               addr,
  output logic                     issue_valid,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || HAZ_LAT < 1) begin : g_param_err
    $error("instr_issue: unsupported DEPTH or HAZ_LAT");
  end

  logic [23:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   head;
  logic          not_empty;
  logic          hazard;
  logic          do_push;
  logic          do_pop;

  logic [3:0]    rs1_q, rs2_q, rd_q, func_q;
  logic [7:0]    addr_q;
  logic          issue_valid_q;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < CW'(DEPTH));
  assign do_push   = in_valid && in_ready;
  assign do_pop    = not_empty && issue_en && !hazard;
  assign stall     = not_empty && issue_en && hazard;

`ifdef ISSUE_HAZARD_CHK_EN
  localparam int BW = $clog2(HAZ_LAT + 1);

  logic [BW-1:0] busy_q [16];

  assign hazard = (busy_q[head[19:16]] != '0) || (busy_q[head[15:12]] != '0);

  // A fresh issue to rd reloads its counter, taking priority over the decrement.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) busy_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (do_pop && head[11:8] == 4'(i)) busy_q[i] <= BW'(HAZ_LAT);
        else if (busy_q[i] != '0)          busy_q[i] <= busy_q[i] - 1'b1;
      end
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk1) begin
    if (do_push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      func_q        <= '0;
      addr_q        <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      issue_valid_q <= do_pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        func_q   <= head[23:20];
        rs1_q    <= head[19:16];
        rs2_q    <= head[15:12];
        rd_q     <= head[11:8];
        addr_q   <= head[7:0];
      end
    end
  end

  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign func        = func_q;
  assign addr        = addr_q;
  assign issue_valid = issue_valid_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: stimulus pushes expected issues into a queue,
// a negedge monitor pops and compares every issued instruction.
module tb_instr_issue;

  localparam int DEPTH   = 4;
  localparam int HAZ_LAT = 3;
  localparam int W       = 24;

`ifdef ISSUE_HAZARD_CHK_EN
  localparam int RAW_GAP   = 4;
  localparam int RAW_STALL = 3;
`else
  localparam int RAW_GAP   = 1;
  localparam int RAW_STALL = 0;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic        issue_en;
  logic [3:0]  o_rs1, o_rs2, o_rd, o_func;
  logic [7:0]  o_addr;
  logic        issue_valid;
  logic        stall;
  logic [2:0]  fifo_count;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           stall_cnt = 0;
  int           iss_edge [256];

  instr_issue #(.DEPTH(DEPTH), .HAZ_LAT(HAZ_LAT)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .issue_en    (issue_en),
    .rs1         (o_rs1),
    .rs2         (o_rs2),
    .rd          (o_rd),
    .func        (o_func),
    .addr        (o_addr),
    .issue_valid (issue_valid),
    .stall       (stall),
    .fifo_count  (fifo_count)
  );

  // clock / reset
  initial forever #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk1) begin
    if (stall) stall_cnt++;
    if (issue_valid) begin
      iss_edge[o_addr] = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got 0x%0h expected none", {o_func, o_rs1, o_rs2, o_rd, o_addr});
      end else begin
        check("issue_fields", {8'h0, o_func, o_rs1, o_rs2, o_rd, o_addr}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  function automatic logic [23:0] mk(input int f, input int a, input int b, input int d, input int ad);
    mk = {f[3:0], a[3:0], b[3:0], d[3:0], ad[7:0]};
  endfunction

  task automatic push_word(input logic [23:0] w, output int edge_n);
    logic acc;
    logic acc_now;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk1);
      acc_now = in_ready;
      @(posedge clk1);
      #1;
      if (acc_now) acc = 1'b1;
    end
    in_valid = 1'b0;
    edge_n   = cyc;
    if (acc) exp_q.push_back(w);
    else begin
      checks++;
      errors++;
      $display("FAIL push_accept: got not accepted expected accepted (0x%0h)", w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk1);
      #2;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  int p_a, p_b, p_c, p_x, p_w2, p_r;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    issue_en = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_fields", {o_func, o_rs1, o_rs2, o_rd, o_addr}, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    idle(2);

    // reset mid-stream: Z issues, three words left buffered, then reset
    issue_en = 1'b1;
    push_word(mk(3, 1, 2, 9, 'h40), p_x);
    push_word(mk(0, 0, 0, 0, 'h41), p_x);
    issue_en = 1'b0;
    push_word(mk(0, 0, 0, 0, 'h42), p_x);
    push_word(mk(0, 0, 0, 0, 'h43), p_x);
    check("pre_rst_count", fifo_count, 3);
    check("hold_rd", o_rd, 9);
    check("hold_addr", o_addr, 'h40);
    check("hold_issue_valid", issue_valid, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_issue_valid", issue_valid, 0);
    check("mid_rst_fields", {o_func, o_rs1, o_rs2, o_rd, o_addr}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    check("post_rst_in_ready", in_ready, 1);
    idle(1);

    // first post-reset reader of r9 must not stall
    stall_cnt = 0;
    issue_en  = 1'b1;
    push_word(mk(0, 9, 0, 1, 'h50), p_r);
    drain();
    check("post_rst_latency", iss_edge['h50], p_r + 1);
    check("post_rst_stall", stall_cnt, 0);
    idle(8);

    // independent back-to-back issue
    stall_cnt = 0;
    push_word(mk(0, 3, 5, 10, 125), p_a);
    push_word(mk(2, 7, 8, 12, 126), p_b);
    drain();
    check("indep_first_latency", iss_edge[125], p_a + 1);
    check("indep_consecutive", iss_edge[126], iss_edge[125] + 1);
    check("indep_stall", stall_cnt, 0);
    idle(8);

    // RAW hazard on r10
    stall_cnt = 0;
    push_word(mk(0, 3, 5, 10, 125), p_a);
    push_word(mk(1, 10, 5, 14, 128), p_c);
    drain();
    check("raw_gap", iss_edge[128], iss_edge[125] + RAW_GAP);
    check("raw_stall_cycles", stall_cnt, RAW_STALL);
    check("raw_rs1", o_rs1, 10);
    idle(8);

    // full back-pressure
    issue_en = 1'b0;
    for (int i = 0; i < 4; i++) push_word(mk(0, 0, 0, i + 1, 'h60 + i), p_x);
    check("full_count", fifo_count, 4);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_instr = mk(0, 0, 0, 5, 'h64);
    repeat (3) begin
      @(negedge clk1);
      check("full_hold_ready", in_ready, 0);
      @(posedge clk1);
      #1;
    end
    check("full_hold_count", fifo_count, 4);
    issue_en = 1'b1;
    @(negedge clk1);
    check("full_pop_ready", in_ready, 0);
    @(posedge clk1);
    #1;
    issue_en = 1'b0;
    check("full_after_pop_count", fifo_count, 3);
    @(negedge clk1);
    check("full_reopen_ready", in_ready, 1);
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 5, 'h64));
    check("full_refill_count", fifo_count, 4);
    issue_en = 1'b1;
    drain();
    idle(2);
    check("full_drained_count", fifo_count, 0);
    idle(8);

    // busy refresh: r10 written twice two issues apart, then read
    push_word(mk(0, 1, 2, 10, 'h70), p_x);
    push_word(mk(0, 1, 2, 6, 'h71), p_x);
    push_word(mk(0, 3, 4, 10, 'h72), p_w2);
    push_word(mk(0, 10, 0, 5, 'h73), p_r);
    drain();
    check("refresh_writer_gap", iss_edge['h72], iss_edge['h70] + 2);
    check("refresh_reader_gap", iss_edge['h73], iss_edge['h72] + RAW_GAP);
    issue_en = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter HAZ_LAT, default 3, meaning cycles a destination register stays busy after issue.
REQ-003 SHALL have port clk1  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer offers an instruction word.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a word this cycle.
REQ-007 SHALL have port in_instr  input  24  instruction word.
- Field layout: {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}.
REQ-008 SHALL have port issue_en  input  1  downstream pipe permits issue.
REQ-009 SHALL have ports rs1, rs2, rd, func  output  4 each  issued register-bank pipe fields.
REQ-010 SHALL have port addr  output  8  issued memory address.
REQ-011 SHALL have port issue_valid  output  1  fields hold a newly issued instruction, one-cycle pulse.
REQ-012 SHALL have port stall  output  1  head instruction is blocked by a hazard.
REQ-013 SHALL have port fifo_count  output  clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-014 SHALL push in_instr into a FIFO on an edge where in_valid && in_ready.
REQ-015 SHALL drive in_ready = (fifo_count < DEPTH) combinationally.
- Full: in_ready low, so no push at full even if a pop occurs the same cycle.
REQ-016 SHALL keep one per-register busy counter for each of the 16 registers, HAZ_LAT width.
REQ-017 SHALL define hazard = busy[head.rs1] != 0 || busy[head.rs2] != 0.
REQ-018 SHALL issue on an edge where FIFO non-empty && issue_en && !hazard.
- Action: pop head, register all five fields, set issue_valid = 1.
REQ-019 SHALL otherwise clear issue_valid = 0; rs1/rs2/rd/func/addr hold their last issued values.
REQ-020 SHALL each cycle decrement every non-zero busy counter.
- On issue, busy[rd] loads HAZ_LAT, overriding its decrement.
REQ-021 SHALL drive stall = non-empty && issue_en && hazard, combinationally.
REQ-022 SHALL give dependent issue edges exactly HAZ_LAT+1 edges after the producer's issue edge, with stall high HAZ_LAT cycles between them.
REQ-023 SHALL allow push and pop on the same edge with fifo_count unchanged, including when the FIFO is at count 1.
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL never issue from an empty FIFO; a word pushed into an empty FIFO is issuable on the following edge, not the push edge.
REQ-026 SHALL add 1 cycle minimum latency from push to issue_valid.

Reset
REQ-027 SHALL, while rst_n low, asynchronously empty the FIFO and zero the pointers, fifo_count, and all busy counters.
REQ-028 SHALL, while rst_n low, drive rs1, rs2, rd, func, addr, and issue_valid to 0.
REQ-029 SHALL discard buffered and in-flight hazard state on reset mid-operation; the first post-reset instruction never stalls.
REQ-030 SHALL report in_ready = 1 during and after reset.

Configuration
REQ-031 SHALL, with macro ISSUE_HAZARD_CHK_EN defined, implement the busy counters and stall rule per REQ-016..REQ-022.
REQ-032 SHALL, without ISSUE_HAZARD_CHK_EN, omit the busy counters and tie hazard and stall to 0.
- Issue then depends only on non-empty && issue_en.

Verification
REQ-033 SHALL cover reset: reset mid-stream with 3 words buffered -> fifo_count=0, issue_valid=0, all fields 0, in_ready=1.
REQ-034 SHALL cover independent issue: push {0,3,5,10,125} and {2,7,8,12,126} back-to-back with issue_en=1.
- Response: issue_valid on consecutive cycles, rd=10 then rd=12, addr=125 then 126, stall never high.
REQ-035 SHALL cover a RAW hazard: push {0,3,5,10,125} then {1,10,5,14,128}.
- Response: stall high 3 cycles, second issue 4 edges after first, rs1=10.
REQ-036 SHALL cover full back-pressure: issue_en=0, push 5 words.
- Response: in_ready low after 4th push, fifo_count=4, 5th word not accepted until issue_en=1 pops one.
REQ-037 SHALL cover the build without ISSUE_HAZARD_CHK_EN: repeat REQ-035.
- Response: both issue on consecutive cycles, stall stays 0.
REQ-038 SHALL cover busy refresh: rd=10 issued twice, 2 cycles apart, then a reader of r10.
- Response: reader issues 4 edges after the second writer.
